// File: rtl/hazard_flush_ctrl.sv
// hazard_flush_ctrl: pipeline hazard and exception-sequencing controller.
// Generates per-stage flush strobes, the PC/IF-ID hold and the PC redirect.
// It sequences illegal-instruction (and optionally interrupt) entry through
// RUN -> DRAIN -> FLUSH -> REDIRECT.
// Optional feature macro: PIPE_IRQ_EN (external interrupt entry). When it is
// undefined, irq/kernel are ignored and exc_vec is always ILLOP_VEC.
module hazard_flush_ctrl #(
    parameter logic [31:0] IRQ_VEC      = 32'h8000_0004,
    parameter logic [31:0] ILLOP_VEC    = 32'h8000_0008,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        irq,
    input  logic        kernel,
    input  logic        illop_ID,
    input  logic        load_use,
    input  logic        branch_taken_EX,
    input  logic [31:0] PC_ID,
    output logic        IFID_X,
    output logic        IDEX_X,
    output logic        EXMEM_X,
    output logic        MEMWB_X,
    output logic        pc_hold,
    output logic        exc_load,
    output logic [31:0] exc_vec,
    output logic [31:0] epc_out,
    output logic        busy
);

    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_DRAIN    = 2'd1;
    localparam logic [1:0] S_FLUSH    = 2'd2;
    localparam logic [1:0] S_REDIRECT = 2'd3;

    localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES - 1);

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [2:0]  cnt;
    logic [2:0]  cnt_nxt;
    logic [31:0] epc_q;
    logic        exc_req;
    logic        exc_take;
    logic [31:0] vec_sel;

    logic ifid_r, idex_r, exmem_r, memwb_r, hold_r, load_r;

`ifdef PIPE_IRQ_EN
    logic cause_irq;

    assign exc_req = illop_ID | (irq & ~kernel);
    assign vec_sel = cause_irq ? IRQ_VEC : ILLOP_VEC;

    // Cause is latched only on entry; illegal opcode beats interrupt.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset)
            cause_irq <= 1'b0;
        else if (exc_take)
            cause_irq <= ~illop_ID;
    end
`else
    logic unused_irq_inputs;

    assign unused_irq_inputs = irq | kernel;
    assign exc_req           = illop_ID;
    assign vec_sel           = ILLOP_VEC;
`endif

    // A taken branch squashes the ID instruction, so it also squashes entry.
    assign exc_take = (state == S_RUN) && !branch_taken_EX && exc_req;

    // State, drain counter and return PC registers.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state <= S_RUN;
            cnt   <= '0;
            epc_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (exc_take)
                epc_q <= PC_ID;
        end
    end

    // Next-state and drain-counter sequencing.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_RUN: begin
                if (exc_take) begin
                    state_nxt = S_DRAIN;
                    cnt_nxt   = DRAIN_INIT;
                end
            end
            S_DRAIN: begin
                if (cnt == 3'd0)
                    state_nxt = S_FLUSH;
                else
                    cnt_nxt = cnt - 3'd1;
            end
            S_FLUSH:    state_nxt = S_REDIRECT;
            S_REDIRECT: state_nxt = S_RUN;
            default:    state_nxt = S_RUN;
        endcase
    end

    // Output decode: Mealy in RUN, Moore in the exception states.
    always_comb begin
        ifid_r  = 1'b0;
        idex_r  = 1'b0;
        exmem_r = 1'b0;
        memwb_r = 1'b0;
        hold_r  = 1'b0;
        load_r  = 1'b0;
        case (state)
            S_RUN: begin
                if (branch_taken_EX) begin
                    ifid_r = 1'b1;
                    idex_r = 1'b1;
                end else if (exc_req) begin
                    idex_r = 1'b1;
                    hold_r = 1'b1;
                end else if (load_use) begin
                    idex_r = 1'b1;
                    hold_r = 1'b1;
                end
            end
            S_DRAIN: begin
                idex_r = 1'b1;
                hold_r = 1'b1;
            end
            S_FLUSH: begin
                ifid_r  = 1'b1;
                idex_r  = 1'b1;
                exmem_r = 1'b1;
                memwb_r = 1'b1;
                hold_r  = 1'b1;
            end
            S_REDIRECT: begin
                ifid_r = 1'b1;
                load_r = 1'b1;
            end
            default: ;
        endcase
    end

    // Every output is held at zero while reset is asserted.
    assign IFID_X   = reset & ifid_r;
    assign IDEX_X   = reset & idex_r;
    assign EXMEM_X  = reset & exmem_r;
    assign MEMWB_X  = reset & memwb_r;
    assign pc_hold  = reset & hold_r;
    assign exc_load = reset & load_r;
    assign busy     = reset & (state != S_RUN);
    assign exc_vec  = reset ? vec_sel : '0;
    assign epc_out  = reset ? epc_q : '0;

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Testbench for hazard_flush_ctrl: scoreboard of expected per-cycle outputs,
// produced by a phase-count model of the exception sequence.
module tb_hazard_flush_ctrl;

    localparam int unsigned D     = 2;
    localparam logic [31:0] IRQ_V = 32'h8000_0004;
    localparam logic [31:0] ILL_V = 32'h8000_0008;

    logic        CLK = 1'b0;
    logic        reset;
    logic        irq;
    logic        kernel;
    logic        illop_ID;
    logic        load_use;
    logic        branch_taken_EX;
    logic [31:0] PC_ID;
    logic        IFID_X, IDEX_X, EXMEM_X, MEMWB_X;
    logic        pc_hold, exc_load, busy;
    logic [31:0] exc_vec;
    logic [31:0] epc_out;

    hazard_flush_ctrl #(
        .IRQ_VEC      (IRQ_V),
        .ILLOP_VEC    (ILL_V),
        .DRAIN_CYCLES (D)
    ) dut (
        .CLK             (CLK),
        .reset           (reset),
        .irq             (irq),
        .kernel          (kernel),
        .illop_ID        (illop_ID),
        .load_use        (load_use),
        .branch_taken_EX (branch_taken_EX),
        .PC_ID           (PC_ID),
        .IFID_X          (IFID_X),
        .IDEX_X          (IDEX_X),
        .EXMEM_X         (EXMEM_X),
        .MEMWB_X         (MEMWB_X),
        .pc_hold         (pc_hold),
        .exc_load        (exc_load),
        .exc_vec         (exc_vec),
        .epc_out         (epc_out),
        .busy            (busy)
    );

    always #5 CLK = ~CLK;

    // ctl bit order: {IFID_X, IDEX_X, EXMEM_X, MEMWB_X, pc_hold, exc_load, busy}
    typedef struct packed {
        logic [6:0]  ctl;
        logic [31:0] epc;
        logic        vec_chk;
        logic [31:0] vec;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Model: phase 0 = RUN, 1..D = DRAIN, D+1 = FLUSH, D+2 = REDIRECT.
    int unsigned m_phase = 0;
    logic [31:0] m_epc   = '0;
    logic        m_irq   = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] vec_for(input logic cause_irq);
`ifdef PIPE_IRQ_EN
        return cause_irq ? IRQ_V : ILL_V;
`else
        return cause_irq ? ILL_V : ILL_V;
`endif
    endfunction

    task automatic step(input logic rst, input logic br, input logic il, input logic lu,
                        input logic iq, input logic kn, input logic [31:0] pc, input string tag);
        exp_t        e;
        exp_t        got;
        int unsigned nphase;
        logic [31:0] nepc;
        logic        nirq;
        logic        exc;
        reset           = rst;
        branch_taken_EX = br;
        illop_ID        = il;
        load_use        = lu;
        irq             = iq;
        kernel          = kn;
        PC_ID           = pc;
`ifdef PIPE_IRQ_EN
        exc = il || (iq && !kn);
`else
        exc = il;
`endif
        e      = '0;
        nphase = m_phase;
        nepc   = m_epc;
        nirq   = m_irq;
        if (!rst) begin
            e.vec_chk = 1'b1;
            nphase    = 0;
            nepc      = '0;
            nirq      = 1'b0;
        end else begin
            e.epc = m_epc;
            if (m_phase == 0) begin
                if (br)
                    e.ctl = 7'b1100000;
                else if (exc) begin
                    e.ctl  = 7'b0100100;
                    nphase = 1;
                    nepc   = pc;
                    nirq   = !il;
                end else if (lu)
                    e.ctl = 7'b0100100;
            end else if (m_phase <= D) begin
                e.ctl  = 7'b0100101;
                nphase = m_phase + 1;
            end else if (m_phase == D + 1) begin
                e.ctl     = 7'b1111101;
                e.vec_chk = 1'b1;
                e.vec     = vec_for(m_irq);
                nphase    = m_phase + 1;
            end else begin
                e.ctl     = 7'b1000011;
                e.vec_chk = 1'b1;
                e.vec     = vec_for(m_irq);
                nphase    = 0;
            end
        end
        sb.push_back(e);
        @(negedge CLK);
        got = sb.pop_front();
        check_val({tag, ".ctl"}, 32'({IFID_X, IDEX_X, EXMEM_X, MEMWB_X, pc_hold, exc_load, busy}),
                  32'(got.ctl));
        check_val({tag, ".epc"}, epc_out, got.epc);
        if (got.vec_chk)
            check_val({tag, ".vec"}, exc_vec, got.vec);
        @(posedge CLK);
        m_phase = nphase;
        m_epc   = nepc;
        m_irq   = nirq;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; irq = 1'b0; kernel = 1'b0; illop_ID = 1'b0;
        load_use = 1'b0; branch_taken_EX = 1'b0; PC_ID = '0;
        #1;
        // reset with every input active: outputs forced low
        step(0, 1, 1, 1, 1, 0, 32'hDEAD_BEEF, "rst_drv0");
        step(0, 1, 1, 1, 1, 0, 32'hDEAD_BEEF, "rst_drv1");
        step(1, 0, 0, 0, 0, 0, 32'h0,         "idle_after_rst");
        // single load-use bubble
        step(1, 0, 0, 1, 0, 0, 32'h0,         "load_use");
        step(1, 0, 0, 0, 0, 0, 32'h0,         "lu_release");
        // branch beats illegal opcode
        step(1, 1, 1, 0, 0, 0, 32'h0000_1234, "br_vs_illop");
        step(1, 0, 0, 0, 0, 0, 32'h0,         "after_br");
        // illegal opcode entry (load_use also present), inputs noisy while busy
        step(1, 0, 1, 1, 0, 0, 32'h0040_0010, "illop_entry");
        step(1, 0, 1, 0, 0, 0, 32'h0050_0000, "drain1");
        step(1, 1, 1, 1, 0, 0, 32'h0050_0004, "drain2");
        step(1, 0, 0, 0, 0, 0, 32'h0,         "flush");
        step(1, 0, 0, 0, 0, 0, 32'h0,         "redirect");
        step(1, 0, 0, 0, 0, 0, 32'h0,         "back_run");
`ifdef PIPE_IRQ_EN
        for (int i = 0; i < 3; i++)
            step(1, 0, 0, 0, 1, 1, 32'h8000_0100, "irq_kernel_masked");
        step(1, 0, 0, 0, 1, 0, 32'h0040_0200, "irq_entry");
        step(1, 0, 0, 0, 1, 0, 32'h0040_0204, "irq_drain1");
        step(1, 0, 0, 0, 1, 0, 32'h0040_0208, "irq_drain2");
        step(1, 0, 0, 0, 1, 0, 32'h0040_020C, "irq_flush");
        step(1, 0, 0, 0, 0, 0, 32'h0,         "irq_redirect");
        step(1, 0, 0, 0, 0, 0, 32'h0,         "irq_back_run");
`else
        for (int i = 0; i < 10; i++)
            step(1, 0, 0, 0, 1, 0, 32'h0040_0300, "irq_ignored");
`endif
        // reset mid-DRAIN abandons the sequence
        step(1, 0, 1, 0, 0, 0, 32'h0060_0020, "entry2");
        step(1, 0, 0, 0, 0, 0, 32'h0,         "entry2_drain1");
        step(0, 1, 1, 1, 1, 0, 32'h0060_0024, "rst_mid_drain");
        step(1, 0, 0, 0, 0, 0, 32'h0,         "post_rst_run");
        step(1, 0, 0, 1, 0, 0, 32'h0,         "post_rst_lu");
        // fresh entry records the new return PC
        step(1, 0, 1, 0, 0, 0, 32'h0070_0040, "entry3");
        for (int i = 0; i < 5; i++)
            step(1, 0, 0, 0, 0, 0, 32'h0, "entry3_seq");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
